alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - 8-bit registered ALU/accumulator. One operation per rising clock edge selected by s.
// - Result register f and carry/borrow flag cout are both registered.
// - Standalone datapath block, driven directly by operand, control and select inputs.
// - One clock. Reset is asynchronous and active-low.
// PARAMETERS
// - WIDTH  8  operand/result width (a, b, f). All arithmetic is mod 2^WIDTH.
// PORTS
// - clock  in   1      rising-edge clock
// - reset  in   1      asynchronous active-low reset; clears f and cout
// - a      in   WIDTH  operand A
// - b      in   WIDTH  operand B
// - L      in   1      load: f <= a (overrides s)
// - En     in   1      enable: 0 = hold f and cout
// - s      in   2      operation select
// - f      out  WIDTH  registered result/accumulator
// - cout   out  1      registered carry (add) / borrow (sub); 0 for load and logic
// BEHAVIOUR
// - reset=0: f=0 and cout=0 immediately, with no clock edge needed. Held at 0 while reset=0.
// - Register update priority on each posedge while reset=1:
//   1. En=0: hold f and cout.
//   2. L=1: f<=a, cout<=0.
//   3. Otherwise by s:
//      - 00 ADD: {cout,f} <= a + b (9-bit sum).
//      - 01 ACC: {cout,f} <= f + a. Accumulates a every cycle.
//      - 10 SUB: {cout,f} <= {1'b0,f} - {1'b0,b}. cout=1 iff b > f (borrow). f wraps mod 256.
//      - 11 XOR: f <= a ^ b, cout <= 0.
// - Latency: 1 cycle. Inputs sampled at a posedge appear on f/cout after that edge.
// - cout is per-operation, not sticky. The next ADD/ACC/SUB overwrites it.
// - s, a and b may change on any cycle. The value present at the edge is used.
// - Reset asserted mid-operation: the accumulation is abandoned and f=0 at once.
//   The first edge after reset deassertion operates on f=0.
// - Reset deasserted coincident with a posedge: that edge may be ignored; the next edge is valid.
// - No combinational path from inputs to f/cout.
// STRUCTURE
// - Shared package alu_pkg: localparams OP_ADD=2'b00, OP_ACC=2'b01, OP_SUB=2'b10, OP_XOR=2'b11; WIDTH default.
// - Sub-module alu_addsub: combinational (WIDTH+1)-bit add/subtract.
//   - Inputs: x, y, sub.
//   - Outputs: sum, carry.
//   - Shared by ADD, ACC and SUB. The operand mux selects x=a or f, y=a or b.
// - Top alu: operand mux, XOR unit, result mux, and one always block with async reset for f/cout.
// TESTING
// - Reset: reset=0 with a=20, b=30, s=00 -> f=0, cout=0, no edge needed.
//   Release, then one edge -> f=50, cout=0.
// - ACC: from f=0, reset=1, s=01.
//   - a=20: edges give f=20,40,60. Change a=25 -> f=85.
//   - a=200 from f=100 -> f=44 (0x2C), cout=1.
// - SUB: from f=0, s=10, b=30 -> f=226 (0xE2), cout=1.
//   Next edge -> f=196, cout=0.
// - XOR: s=11, a=8'hAA, b=8'h55 -> f=8'hFF, cout=0.
//   a=b=8'hAA -> f=0.
// - Control: En=0 for 3 edges -> f/cout unchanged under any s.
//   L=1, a=8'h3C -> f=8'h3C, cout=0.
//   L=1 with En=0 -> hold.
// - Async reset mid-ACC: drop reset between edges -> f=0 before the next edge.
//   Re-release -> accumulation restarts from 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU/accumulator.
// Operation select encodings and default datapath width.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ACC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_addsub.sv
// Combinational (W+1)-bit adder/subtractor shared by ADD, ACC and SUB.
// carry is the add carry-out, or the borrow when sub is set.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] res;

  always_comb begin
    if (sub) res = {1'b0, x} - {1'b0, y};
    else     res = {1'b0, x} + {1'b0, y};
  end

  assign sum   = res[W-1:0];
  assign carry = res[W];

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU/accumulator: ADD, ACC, SUB, XOR plus load.
// f and cout update on the rising edge; reset clears them at once.
module alu
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         L,
  input  logic         En,
  input  logic [1:0]   s,
  output logic [W-1:0] f,
  output logic         cout
);

  logic [W-1:0] f_q, f_d;
  logic         c_q, c_d;
  logic [W-1:0] x, y, sum;
  logic         sub, carry;
  logic [W-1:0] xr;

  // ACC and SUB both start from the accumulator
  assign x   = (s == OP_ACC || s == OP_SUB) ? f_q : a;
  assign y   = (s == OP_ACC) ? a : b;
  assign sub = (s == OP_SUB);
  assign xr  = a ^ b;

  alu_addsub #(.W(W)) u_addsub (
    .x     (x),
    .y     (y),
    .sub   (sub),
    .sum   (sum),
    .carry (carry)
  );

  always_comb begin
    f_d = f_q;
    c_d = c_q;
    if (!En) begin
      f_d = f_q;
      c_d = c_q;
    end else if (L) begin
      f_d = a;
      c_d = 1'b0;
    end else begin
      unique case (s)
        OP_ADD,
        OP_ACC,
        OP_SUB: begin
          f_d = sum;
          c_d = carry;
        end
        OP_XOR: begin
          f_d = xr;
          c_d = 1'b0;
        end
        default: begin
          f_d = f_q;
          c_d = c_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_q <= '0;
      c_q <= 1'b0;
    end else begin
      f_q <= f_d;
      c_q <= c_d;
    end
  end

  assign f    = f_q;
  assign cout = c_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios then random traffic
// compared against an integer-arithmetic reference model.
module tb_alu;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] a, b;
  logic       L, En;
  logic [1:0] s;
  logic [7:0] f;
  logic       cout;

  int checks = 0;
  int errors = 0;
  int mf = 0;
  int mc = 0;

  alu dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .b     (b),
    .L     (L),
    .En    (En),
    .s     (s),
    .f     (f),
    .cout  (cout)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed cout/f=%h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(int ia, int ib, bit il, bit ien, int is);
    int t;
    if (!ien) return;
    if (il) begin
      mf = ia;
      mc = 0;
      return;
    end
    case (is)
      0: begin t = ia + ib; mf = t % 256; mc = t / 256; end
      1: begin t = mf + ia; mf = t % 256; mc = t / 256; end
      2: begin
        mc = (ib > mf) ? 1 : 0;
        mf = (mf - ib + 256) % 256;
      end
      default: begin mf = ia ^ ib; mc = 0; end
    endcase
  endfunction

  task automatic step(string tag, logic [7:0] ia, logic [7:0] ib,
                      logic il, logic ien, logic [1:0] is);
    a = ia; b = ib; L = il; En = ien; s = is;
    @(posedge clock);
    model(int'(ia), int'(ib), il, ien, int'(is));
    #1;
    chk(tag, {cout, f}, {mc[0], mf[7:0]});
  endtask

  task automatic stepx(string tag, logic [7:0] ia, logic [7:0] ib,
                       logic il, logic ien, logic [1:0] is,
                       logic [7:0] ef, logic ec);
    step(tag, ia, ib, il, ien, is);
    chk({tag, "_lit"}, {cout, f}, {ec, ef});
  endtask

  task automatic rst_pulse(string tag);
    reset = 1'b0;
    #2;
    mf = 0;
    mc = 0;
    chk(tag, {cout, f}, 9'h000);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    a = 8'd20; b = 8'd30; s = 2'b00; L = 1'b0; En = 1'b1;
    #3;
    chk("reset_async", {cout, f}, 9'h000);
    reset = 1'b1;
    stepx("add_first", 8'd20, 8'd30, 0, 1, 2'b00, 8'd50, 0);

    rst_pulse("rst_acc");
    stepx("acc1", 8'd20, 8'd0, 0, 1, 2'b01, 8'd20, 0);
    stepx("acc2", 8'd20, 8'd0, 0, 1, 2'b01, 8'd40, 0);
    stepx("acc3", 8'd20, 8'd0, 0, 1, 2'b01, 8'd60, 0);
    stepx("acc4", 8'd25, 8'd0, 0, 1, 2'b01, 8'd85, 0);
    stepx("load100", 8'd100, 8'd0, 1, 1, 2'b01, 8'd100, 0);
    stepx("acc_wrap", 8'd200, 8'd0, 0, 1, 2'b01, 8'h2C, 1);

    rst_pulse("rst_sub");
    stepx("sub_borrow", 8'd0, 8'd30, 0, 1, 2'b10, 8'd226, 1);
    stepx("sub_noborrow", 8'd0, 8'd30, 0, 1, 2'b10, 8'd196, 0);

    stepx("xor_ff", 8'hAA, 8'h55, 0, 1, 2'b11, 8'hFF, 0);
    stepx("xor_zero", 8'hAA, 8'hAA, 0, 1, 2'b11, 8'h00, 0);

    stepx("add_carry", 8'd200, 8'd100, 0, 1, 2'b00, 8'd44, 1);
    stepx("hold0", 8'h11, 8'h22, 0, 0, 2'b00, 8'd44, 1);
    stepx("hold1", 8'h33, 8'h44, 0, 0, 2'b01, 8'd44, 1);
    stepx("hold2", 8'h55, 8'h66, 0, 0, 2'b10, 8'd44, 1);
    stepx("load3c", 8'h3C, 8'h99, 1, 1, 2'b10, 8'h3C, 0);
    stepx("load_hold", 8'h77, 8'h99, 1, 0, 2'b00, 8'h3C, 0);

    stepx("macc1", 8'd10, 8'd0, 0, 1, 2'b01, 8'h46, 0);
    stepx("macc2", 8'd10, 8'd0, 0, 1, 2'b01, 8'h50, 0);
    rst_pulse("rst_mid_acc");
    stepx("macc_restart", 8'd10, 8'd0, 0, 1, 2'b01, 8'd10, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) rst_pulse("rnd_rst");
      step("rnd", 8'($urandom), 8'($urandom),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) != 0),
           2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
